// File: rtl/nonce_collector_if.sv
// Bus bundle between nonce_collector (master) and the macro array / register bank (slave).
// NONCE_COLLECTOR_TIMESTAMP_EN adds the STAMP_OUT head-stamp signal.
interface nonce_collector_if #(
    parameter int NUM_MACROS = 4,
    parameter int FIFO_DEPTH = 4
);
    logic                          SCAN_EN;
    logic [NUM_MACROS-1:0]         DATA_AVAILABLE;
    logic [7:0]                    DATA_FROM_HASH;
    logic [NUM_MACROS-1:0]         MACRO_RD_SELECT;
    logic [5:0]                    HASH_ADDR;
    logic                          POP;
    logic [31:0]                   NONCE_OUT;
    logic [3:0]                    MACRO_ID_OUT;
    logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT;
    logic                          FIFO_EMPTY;
    logic                          FIFO_FULL;
    logic                          IRQ;
`ifdef NONCE_COLLECTOR_TIMESTAMP_EN
    logic [15:0]                   STAMP_OUT;
`endif

    modport master (
        input  SCAN_EN, DATA_AVAILABLE, DATA_FROM_HASH, POP,
        output MACRO_RD_SELECT, HASH_ADDR, NONCE_OUT, MACRO_ID_OUT,
               FIFO_COUNT, FIFO_EMPTY, FIFO_FULL, IRQ
`ifdef NONCE_COLLECTOR_TIMESTAMP_EN
        , output STAMP_OUT
`endif
    );

    modport slave (
        output SCAN_EN, DATA_AVAILABLE, DATA_FROM_HASH, POP,
        input  MACRO_RD_SELECT, HASH_ADDR, NONCE_OUT, MACRO_ID_OUT,
               FIFO_COUNT, FIFO_EMPTY, FIFO_FULL, IRQ
`ifdef NONCE_COLLECTOR_TIMESTAMP_EN
        , input STAMP_OUT
`endif
    );
endinterface

// File: rtl/nonce_collector.sv
// Round-robin nonce collector: burst-reads pending macro results into a small FIFO with IRQ.
// Optional NONCE_COLLECTOR_TIMESTAMP_EN stores a 16-bit free-running stamp with each entry.
module nonce_collector #(
    parameter int         NUM_MACROS  = 4,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [5:0] RESULT_BASE = 6'h00,
    parameter logic [5:0] CLEAR_ADDR  = 6'h3F
) (
    input  logic              M1_CLK,
    input  logic              RST,
    nonce_collector_if.master bus
);
    localparam int SELW = (NUM_MACROS > 1) ? $clog2(NUM_MACROS) : 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;

    typedef enum logic [1:0] {IDLE, READ, LAST, WAIT_CLR} state_t;

    typedef struct packed {
`ifdef NONCE_COLLECTOR_TIMESTAMP_EN
        logic [15:0] stamp;
`endif
        logic [3:0]  id;
        logic [31:0] nonce;
    } entry_t;

    state_t                 state_q;
    logic [SELW-1:0]        sel_q, rr_q;
    logic [1:0]             cnt_q;
    logic [23:0]            nonce_q;
    logic [NUM_MACROS-1:0]  rd_sel_q;
    logic [5:0]             addr_q;

    logic [PW-1:0]          wr_q, rd_q;
    logic [CW-1:0]          fcnt_q, fcnt_d;
    logic                   irq_q;
    entry_t                 fifo_q [FIFO_DEPTH];
    entry_t                 push_e, head;
    logic                   push, pop, empty, full;

    logic [SELW-1:0]        pick;
    logic                   pick_vld;

`ifdef NONCE_COLLECTOR_TIMESTAMP_EN
    logic [15:0]            ts_q;

    always_ff @(posedge M1_CLK or posedge RST) begin
        if (RST) ts_q <= '0;
        else     ts_q <= ts_q + 16'd1;
    end
`endif

    // First pending macro at or after rr_q; scanning downward lets the nearest one win.
    always_comb begin : pick_c
        int j;
        j        = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = NUM_MACROS - 1; i >= 0; i--) begin
            j = int'(rr_q) + i;
            if (j >= NUM_MACROS) j = j - NUM_MACROS;
            if (bus.DATA_AVAILABLE[j[SELW-1:0]]) begin
                pick     = j[SELW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge M1_CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
            nonce_q  <= '0;
            rd_sel_q <= '0;
            addr_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.SCAN_EN && pick_vld && !full) begin
                        sel_q    <= pick;
                        rr_q     <= (pick == SELW'(NUM_MACROS - 1)) ? '0 : pick + 1'b1;
                        cnt_q    <= '0;
                        rd_sel_q <= {{(NUM_MACROS-1){1'b0}}, 1'b1} << pick;
                        addr_q   <= RESULT_BASE;
                        state_q  <= READ;
                    end
                end
                READ: begin
                    // Data trails the address by one cycle, so byte n lands while addr n+1 is out.
                    case (cnt_q)
                        2'd1:    nonce_q[7:0]   <= bus.DATA_FROM_HASH;
                        2'd2:    nonce_q[15:8]  <= bus.DATA_FROM_HASH;
                        2'd3:    nonce_q[23:16] <= bus.DATA_FROM_HASH;
                        default: ;
                    endcase
                    if (cnt_q == 2'd3) begin
                        addr_q  <= CLEAR_ADDR;
                        state_q <= LAST;
                    end else begin
                        cnt_q  <= cnt_q + 2'd1;
                        addr_q <= RESULT_BASE + 6'(cnt_q) + 6'd1;
                    end
                end
                LAST: begin
                    rd_sel_q <= '0;
                    addr_q   <= '0;
                    cnt_q    <= '0;
                    state_q  <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    // Bounded wait: a flag that never drops is simply picked up again later.
                    if (!bus.DATA_AVAILABLE[sel_q] || cnt_q == 2'd3) state_q <= IDLE;
                    else                                             cnt_q   <= cnt_q + 2'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign push  = (state_q == LAST);
    assign empty = (fcnt_q == '0);
    assign full  = (fcnt_q == CW'(FIFO_DEPTH));
    assign pop   = bus.POP && !empty;

    always_comb begin
        push_e       = '0;
        push_e.id    = 4'(sel_q);
        push_e.nonce = {bus.DATA_FROM_HASH, nonce_q};
`ifdef NONCE_COLLECTOR_TIMESTAMP_EN
        push_e.stamp = ts_q;
`endif
    end

    always_comb begin
        fcnt_d = fcnt_q;
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge M1_CLK or posedge RST) begin
        if (RST) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
            irq_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_q] <= push_e;
                wr_q         <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            fcnt_q <= fcnt_d;
            irq_q  <= (fcnt_d != '0);
        end
    end

    assign head                = fifo_q[rd_q];
    assign bus.MACRO_RD_SELECT = rd_sel_q;
    assign bus.HASH_ADDR       = addr_q;
    assign bus.NONCE_OUT       = empty ? '0 : head.nonce;
    assign bus.MACRO_ID_OUT    = empty ? '0 : head.id;
    assign bus.FIFO_COUNT      = fcnt_q;
    assign bus.FIFO_EMPTY      = empty;
    assign bus.FIFO_FULL       = full;
    assign bus.IRQ             = irq_q;
`ifdef NONCE_COLLECTOR_TIMESTAMP_EN
    assign bus.STAMP_OUT       = empty ? '0 : head.stamp;
`endif
endmodule

// File: tb/tb_nonce_collector.sv
// Directed + randomized bench for nonce_collector with a behavioural macro-array model.
module tb_nonce_collector;
    localparam int NM = 4;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nonce_collector_if #(.NUM_MACROS(NM), .FIFO_DEPTH(FD)) bus();
    nonce_collector #(.NUM_MACROS(NM), .FIFO_DEPTH(FD)) dut (.M1_CLK(clk), .RST(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    logic [7:0]    mem [NM][64];
    logic [NM-1:0] auto_clr = '1;
    logic [NM-1:0] da_en    = '0;
    int            set_gen [NM];
    int            clr_gen [NM];
    logic [NM-1:0] last_sel  = '0;
    logic [5:0]    last_addr = '0;
    int            rr_model  = 0;

    typedef struct {int id; logic [31:0] nonce;} exp_t;
    exp_t q[$];

    // A flag is pending while enabled and not cleared since its last raise.
    always_comb begin
        for (int i = 0; i < NM; i++)
            bus.DATA_AVAILABLE[i] = da_en[i] && (clr_gen[i] != set_gen[i]);
    end

    // Macro array: read data one cycle after the address; a clear read drops the flag.
    always @(negedge clk) begin
        bus.DATA_FROM_HASH = 8'h00;
        for (int i = 0; i < NM; i++) begin
            if (last_sel[i]) begin
                bus.DATA_FROM_HASH = mem[i][last_addr];
                if (last_addr == 6'h3F && auto_clr[i]) clr_gen[i] = set_gen[i];
            end
        end
        last_sel  = bus.MACRO_RD_SELECT;
        last_addr = bus.HASH_ADDR;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic raise(input logic [NM-1:0] m);
        for (int i = 0; i < NM; i++) if (m[i]) begin
            da_en[i] = 1'b1;
            set_gen[i]++;
        end
    endtask

    task automatic lower(input logic [NM-1:0] m);
        for (int i = 0; i < NM; i++) if (m[i]) da_en[i] = 1'b0;
    endtask

    task automatic fill(input int m);
        for (int a = 0; a < 4; a++) mem[m][a] = 8'($urandom);
    endtask

    function automatic logic [31:0] nonce_of(input int m);
        return {mem[m][3], mem[m][2], mem[m][1], mem[m][0]};
    endfunction

    task automatic pop_one();
        bus.POP = 1'b1;
        tick();
        bus.POP = 1'b0;
    endtask

    // Expected service order: ascending scan of the pending set starting at the rr pointer.
    task automatic expect_scan(input logic [NM-1:0] mask);
        int last;
        last = -1;
        for (int k = 0; k < NM; k++) begin
            int m;
            m = (rr_model + k) % NM;
            if (mask[m]) begin
                q.push_back('{m, nonce_of(m)});
                last = m;
            end
        end
        if (last >= 0) rr_model = (last + 1) % NM;
    endtask

    task automatic check_head_pop(input string tag, input exp_t e);
        check({tag, "_id"}, 64'(bus.MACRO_ID_OUT), 64'(e.id));
        check({tag, "_nonce"}, 64'(bus.NONCE_OUT), 64'(e.nonce));
        pop_one();
    endtask

    initial begin
        logic [5:0]    exp_addr [5];
        logic [NM-1:0] mask;
        int            excl, m, r;
        logic          sawsel;

        exp_addr[0] = 6'h00; exp_addr[1] = 6'h01; exp_addr[2] = 6'h02;
        exp_addr[3] = 6'h03; exp_addr[4] = 6'h3F;
        for (int i = 0; i < NM; i++) begin
            set_gen[i] = 0;
            clr_gen[i] = 0;
            for (int a = 0; a < 64; a++) mem[i][a] = 8'($urandom);
        end
        rst = 1'b1;
        bus.SCAN_EN = 1'b0;
        bus.POP     = 1'b0;
        wait_cycles(2);
        check("rst_sel",   64'(bus.MACRO_RD_SELECT), 64'(0));
        check("rst_addr",  64'(bus.HASH_ADDR), 64'(0));
        check("rst_nonce", 64'(bus.NONCE_OUT), 64'(0));
        check("rst_id",    64'(bus.MACRO_ID_OUT), 64'(0));
        check("rst_cnt",   64'(bus.FIFO_COUNT), 64'(0));
        check("rst_empty", 64'(bus.FIFO_EMPTY), 64'(1));
        check("rst_full",  64'(bus.FIFO_FULL), 64'(0));
        check("rst_irq",   64'(bus.IRQ), 64'(0));
        rst = 1'b0;
        tick();

        // Single result from macro 2 with exact address sequence and latency
        mem[2][0] = 8'h11; mem[2][1] = 8'h22; mem[2][2] = 8'h33; mem[2][3] = 8'h44;
        bus.SCAN_EN = 1'b1;
        raise(4'b0100);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("single_addr", 64'(bus.HASH_ADDR), 64'(exp_addr[k]));
            check("single_sel",  64'(bus.MACRO_RD_SELECT), 64'(4'b0100));
            check("single_irq_early", 64'(bus.IRQ), 64'(0));
        end
        tick();
        check("single_cnt",   64'(bus.FIFO_COUNT), 64'(1));
        check("single_irq",   64'(bus.IRQ), 64'(1));
        check("single_nonce", 64'(bus.NONCE_OUT), 64'(32'h44332211));
        check("single_id",    64'(bus.MACRO_ID_OUT), 64'(2));
        rr_model = 3;
        wait_cycles(6);
        pop_one();
        check("single_pop_empty", 64'(bus.FIFO_EMPTY), 64'(1));
        check("single_pop_irq",   64'(bus.IRQ), 64'(0));

        // Pop while empty
        pop_one();
        tick();
        check("epop_cnt",   64'(bus.FIFO_COUNT), 64'(0));
        check("epop_empty", 64'(bus.FIFO_EMPTY), 64'(1));
        check("epop_nonce", 64'(bus.NONCE_OUT), 64'(0));
        check("epop_id",    64'(bus.MACRO_ID_OUT), 64'(0));

        // Guard exit: macro 1 never clears, so it is read twice
        auto_clr = 4'b1101;
        fill(1);
        raise(4'b0010);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 6)  check("guard_cnt1", 64'(bus.FIFO_COUNT), 64'(1));
            if (k == 10) check("guard_idle_sel", 64'(bus.MACRO_RD_SELECT), 64'(0));
            if (k == 11) begin
                check("guard_reread_sel",  64'(bus.MACRO_RD_SELECT), 64'(4'b0010));
                check("guard_reread_addr", 64'(bus.HASH_ADDR), 64'(0));
            end
        end
        bus.SCAN_EN = 1'b0;
        wait_cycles(20);
        check("guard_cnt2", 64'(bus.FIFO_COUNT), 64'(2));
        lower(4'b0010);
        check_head_pop("guard_e0", '{1, nonce_of(1)});
        check_head_pop("guard_e1", '{1, nonce_of(1)});
        rr_model = 2;
        auto_clr = '1;
        bus.SCAN_EN = 1'b1;
        wait_cycles(4);

        // Randomized pending sets, scoreboarded against the round-robin scan order
        for (int rnd = 0; rnd < 4; rnd++) begin
            mask = NM'($urandom_range(1, 15));
            for (int i = 0; i < NM; i++) fill(i);
            q.delete();
            expect_scan(mask);
            raise(mask);
            wait_cycles(60);
            check("rand_cnt", 64'(bus.FIFO_COUNT), 64'(q.size()));
            foreach (q[i]) check_head_pop("rand", q[i]);
            wait_cycles(3);
        end

        // Round-robin to full with no clears, then one extra service after a pop
        auto_clr = '0;
        for (int i = 0; i < NM; i++) fill(i);
        r = rr_model;
        raise(4'hF);
        wait_cycles(60);
        check("rr_cnt",  64'(bus.FIFO_COUNT), 64'(4));
        check("rr_full", 64'(bus.FIFO_FULL), 64'(1));
        sawsel = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus.MACRO_RD_SELECT != '0) sawsel = 1'b1;
        end
        check("rr_no_sel_full", 64'(sawsel), 64'(0));
        check_head_pop("rr_h0", '{r, nonce_of(r)});
        wait_cycles(20);
        bus.SCAN_EN = 1'b0;
        lower(4'hF);
        check("rr_cnt_refill", 64'(bus.FIFO_COUNT), 64'(4));
        for (int k = 1; k <= 4; k++) begin
            m = (r + k) % NM;
            check_head_pop("rr_order", '{m, nonce_of(m)});
        end
        rr_model = (r + 1) % NM;
        auto_clr = '1;
        bus.SCAN_EN = 1'b1;
        wait_cycles(3);

        // Pop coinciding with a push at occupancy 3
        excl = $urandom_range(0, 3);
        mask = 4'hF & ~(4'b0001 << excl);
        for (int i = 0; i < NM; i++) fill(i);
        q.delete();
        expect_scan(mask);
        raise(mask);
        wait_cycles(40);
        check("pp_cnt_pre", 64'(bus.FIFO_COUNT), 64'(3));
        raise(4'b0001 << excl);
        q.push_back('{excl, nonce_of(excl)});
        rr_model = (excl + 1) % NM;
        wait_cycles(5);
        pop_one();
        check("pp_cnt", 64'(bus.FIFO_COUNT), 64'(3));
        check("pp_head_id", 64'(bus.MACRO_ID_OUT), 64'(q[1].id));
        wait_cycles(10);
        check_head_pop("pp_e1", q[1]);
        check_head_pop("pp_e2", q[2]);
        check("pp_e3_id",    64'(bus.MACRO_ID_OUT), 64'(q[3].id));
        check("pp_e3_nonce", 64'(bus.NONCE_OUT), 64'(q[3].nonce));
        check("pp_cnt_end",  64'(bus.FIFO_COUNT), 64'(1));

        // Asynchronous reset in the middle of a burst
        m = $urandom_range(0, 3);
        fill(m);
        raise(4'b0001 << m);
        wait_cycles(3);
        check("rm_addr_pre", 64'(bus.HASH_ADDR), 64'(2));
        #2 rst = 1'b1;
        #1;
        check("rm_sel",   64'(bus.MACRO_RD_SELECT), 64'(0));
        check("rm_addr",  64'(bus.HASH_ADDR), 64'(0));
        check("rm_cnt",   64'(bus.FIFO_COUNT), 64'(0));
        check("rm_empty", 64'(bus.FIFO_EMPTY), 64'(1));
        check("rm_irq",   64'(bus.IRQ), 64'(0));
        check("rm_nonce", 64'(bus.NONCE_OUT), 64'(0));
        #3 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rm_reread_addr", 64'(bus.HASH_ADDR), 64'(exp_addr[k]));
        end
        tick();
        check("rm_cnt_post", 64'(bus.FIFO_COUNT), 64'(1));
        check("rm_id",       64'(bus.MACRO_ID_OUT), 64'(m));
        check("rm_nonce_post", 64'(bus.NONCE_OUT), 64'(nonce_of(m)));
        wait_cycles(5);
        pop_one();
        check("end_empty", 64'(bus.FIFO_EMPTY), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nonce_collector.md
Name: nonce_collector

Overview:
- Sits between the hash macro array and the controller register bank, in the M1 clock domain.
- Round-robin scans the macros' DATA_AVAILABLE flags and burst-reads each pending 4-byte nonce result over the shared MACRO_RD_SELECT / HASH_ADDR / DATA_FROM_HASH bus.
- Queues each result with its macro index in a small FIFO for the register bank to pop, and raises an interrupt while the FIFO is non-empty.

Parameters:
- NUM_MACROS, 4, number of hash macros scanned; equals `NUMBER_OF_MACROS.
- FIFO_DEPTH, 4, result FIFO entries; must be a power of two, at least 2.
- RESULT_BASE, 6'h00, HASH_ADDR of nonce byte 0; bytes 1..3 follow consecutively.
- CLEAR_ADDR, 6'h3F, HASH_ADDR whose read tells the macro to drop DATA_AVAILABLE.

Ports:
- M1_CLK  in  1  block clock.
- RST  in  1  reset; asynchronous, active-high.
- SCAN_EN  in  1  enables starting new macro reads.
- DATA_AVAILABLE  in  NUM_MACROS  per-macro result-pending flag.
- DATA_FROM_HASH  in  8  read data from the selected macro; valid one cycle after address.
- MACRO_RD_SELECT  out  NUM_MACROS  one-hot read select; all-zero when idle.
- HASH_ADDR  out  6  read address.
- POP  in  1  one-cycle strobe that removes the FIFO head.
- NONCE_OUT  out  32  FIFO head nonce, little-endian (byte 0 = bits [7:0]).
- MACRO_ID_OUT  out  4  FIFO head macro index.
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  occupancy.
- FIFO_EMPTY  out  1  occupancy == 0.
- FIFO_FULL  out  1  occupancy == FIFO_DEPTH.
- IRQ  out  1  registered; equals !FIFO_EMPTY.

Behaviour:
- Reset (asynchronous, any state):
  - State = IDLE; FIFO emptied; round-robin pointer = 0.
  - MACRO_RD_SELECT = 0, HASH_ADDR = 0, NONCE_OUT = 0, MACRO_ID_OUT = 0.
  - FIFO_COUNT = 0, FIFO_EMPTY = 1, FIFO_FULL = 0, IRQ = 0.
  - A read cut off mid-burst is discarded; nothing partial enters the FIFO.
- IDLE:
  - Start condition: SCAN_EN=1, any DATA_AVAILABLE bit set, and FIFO_COUNT < FIFO_DEPTH.
  - Choose the first set bit at or after rr_ptr, wrapping modulo NUM_MACROS; latch it as sel.
  - rr_ptr becomes sel+1, wrapping from NUM_MACROS-1 to 0.
  - Go to READ with byte_cnt = 0.
- READ (4 cycles, byte_cnt 0..3):
  - MACRO_RD_SELECT = 1<<sel; HASH_ADDR = RESULT_BASE + byte_cnt.
  - When byte_cnt > 0, capture DATA_FROM_HASH into byte byte_cnt-1.
  - After byte_cnt = 3, go to LAST.
- LAST (1 cycle):
  - Capture byte 3; HASH_ADDR = CLEAR_ADDR with select still asserted.
  - Push {sel, nonce} into the FIFO; go to WAIT_CLR.
- WAIT_CLR:
  - MACRO_RD_SELECT = 0.
  - Return to IDLE when DATA_AVAILABLE[sel] = 0, or after 4 cycles (guard), whichever comes first.
  - With the guard exit, a still-set flag is serviced again later as a new result.
- Latency: a DATA_AVAILABLE rise seen in IDLE gives FIFO_COUNT+1 and IRQ=1 six edges later (detect, 4×READ, LAST).
- SCAN_EN deasserted: no new burst starts; a burst already in progress completes.
- FIFO:
  - NONCE_OUT / MACRO_ID_OUT always show the head entry; they are 0 when empty.
  - POP when empty is ignored.
  - Push and pop in the same cycle: count unchanged, head advances.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow cannot occur: a burst starts only with a free slot, and only one push is ever in flight.
- Full FIFO: macros stay pending; no reads are issued and no data is lost.

Optional Feature:
- Macro: NONCE_COLLECTOR_TIMESTAMP_EN.
- When defined:
  - A 16-bit free-running counter runs on M1_CLK, reset to 0, wrapping at 16'hFFFF.
  - Its value in the LAST cycle is stored with each entry.
  - Extra output port STAMP_OUT (16 bits) shows the head entry's stamp; 0 when empty.
- When undefined: no counter and no STAMP_OUT port; FIFO width is 32+4.

Test Plan:
- Single result: SCAN_EN=1; DATA_AVAILABLE=4'b0100; macro 2 returns bytes 11,22,33,44 at addrs 0..3 -> HASH_ADDR sequence 0,1,2,3,3F, then NONCE_OUT=32'h44332211, MACRO_ID_OUT=2, IRQ=1 six edges after detect.
- Round-robin: all four flags held high with no clears -> serviced in order 0,1,2,3,0; FIFO_FULL=1 after the 4th push; no select asserted while full.
- Pop/push: FIFO holds 3 entries; POP coincides with the push cycle -> FIFO_COUNT stays 3; head equals the second entry.
- Empty pop: POP with FIFO empty -> FIFO_COUNT=0, FIFO_EMPTY=1, outputs 0, no underflow.
- Reset mid-burst: RST asserted during READ byte_cnt=2 -> MACRO_RD_SELECT=0 immediately (async); FIFO_COUNT=0; after release the pending macro is re-read from byte 0.
- Guard exit: DATA_AVAILABLE[1] stays high after the clear read -> IDLE re-entered after 4 WAIT_CLR cycles; macro 1 read again; two identical entries in the FIFO.
